// File: rtl/sequence_monitor_pkg.sv
// Shared types and default widths for the sequence monitor slice.
package seq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } seq_mon_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int HIST_DEPTH = 4;

endpackage

// File: rtl/sequence_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/sequence_monitor.sv
// Checks a generator stream against an arithmetic progression and keeps lock/error status.
// Optional mismatch history buffer is built when SEQ_MON_HIST_EN is defined.
//
// state | meaning
// IDLE  | disarmed, beats ignored
// SEED  | armed, waiting for the first beat to seed the expected value
// TRACK | locked, every beat compared against exp_data
// LOST  | too many consecutive mismatches, beats ignored until start/stop
module sequence_monitor
    import seq_mon_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_MISS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] step,
    output logic [1:0]        state_o,
    output logic              seq_locked,
    output logic [DATA_W-1:0] exp_data,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_pulse
`ifdef SEQ_MON_HIST_EN
    ,
    input  logic [1:0]        hist_idx,
    output logic [DATA_W-1:0] hist_data,
    output logic [2:0]        hist_cnt
`endif
);

    localparam logic [3:0] MAX_MISS_L = MAX_MISS[3:0];

    seq_mon_state_e    state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [3:0]        miss_run_q, miss_run_d;
    logic              err_pulse_q, err_pulse_d;
    logic              seq_locked_q, seq_locked_d;

    logic clr_cnt, beat_ok, beat_seed, beat_match, beat_miss, lost_hit;

    // stop beats start beats in_valid
    assign clr_cnt    = !stop && start;
    assign beat_ok    = !stop && !start && in_valid;
    assign beat_seed  = beat_ok && (state_q == SEED);
    assign beat_match = beat_ok && (state_q == TRACK) && (in_data == exp_q);
    assign beat_miss  = beat_ok && (state_q == TRACK) && (in_data != exp_q);
    assign lost_hit   = beat_miss && ((miss_run_q + 4'd1) == MAX_MISS_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            miss_run_q   <= '0;
            err_pulse_q  <= 1'b0;
            seq_locked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            miss_run_q   <= miss_run_d;
            err_pulse_q  <= err_pulse_d;
            seq_locked_q <= seq_locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = SEED;
        end else if (beat_seed) begin
            state_d = TRACK;
        end else if (lost_hit) begin
            state_d = LOST;
        end
    end

    always_comb begin
        exp_d        = exp_q;
        miss_run_d   = miss_run_q;
        err_pulse_d  = beat_miss;
        seq_locked_d = (state_d == TRACK);
        if (clr_cnt) begin
            miss_run_d = '0;
        end else if (beat_seed) begin
            exp_d = in_data + step;
        end else if (beat_match) begin
            exp_d      = exp_q + step;
            miss_run_d = '0;
        end else if (beat_miss) begin
            exp_d      = in_data + step;
            miss_run_d = miss_run_q + 4'd1;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (beat_match),
        .q     (match_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (beat_miss),
        .q     (err_cnt)
    );

    assign state_o    = state_q;
    assign seq_locked = seq_locked_q;
    assign exp_data   = exp_q;
    assign err_pulse  = err_pulse_q;

`ifdef SEQ_MON_HIST_EN
    logic [DATA_W-1:0] hist_mem_q [HIST_DEPTH];
    logic [DATA_W-1:0] hist_mem_d [HIST_DEPTH];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [2:0]        hist_cnt_q, hist_cnt_d;
    logic [1:0]        rd_ptr;

    always_comb begin
        hist_mem_d = hist_mem_q;
        wr_ptr_d   = wr_ptr_q;
        hist_cnt_d = hist_cnt_q;
        if (clr_cnt) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem_d[i] = '0;
            wr_ptr_d   = '0;
            hist_cnt_d = '0;
        end else if (beat_miss) begin
            hist_mem_d[wr_ptr_q] = in_data;
            wr_ptr_d             = wr_ptr_q + 2'd1;
            if (hist_cnt_q != 3'd4) hist_cnt_d = hist_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            hist_cnt_q <= '0;
        end else begin
            hist_mem_q <= hist_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end

    // wr_ptr points at the next free slot, so newest sits one behind it
    assign rd_ptr    = wr_ptr_q - 2'd1 - hist_idx;
    assign hist_data = hist_mem_q[rd_ptr];
    assign hist_cnt  = hist_cnt_q;
`endif

endmodule

// File: tb/tb_sequence_monitor.sv
// Directed bench for sequence_monitor; SEQ_MON_HIST_EN adds history checks.
module tb_sequence_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, in_valid;
    logic [7:0]  in_data, step;
    logic [1:0]  state_o;
    logic        seq_locked;
    logic [7:0]  exp_data;
    logic [15:0] match_cnt, err_cnt;
    logic        err_pulse;
`ifdef SEQ_MON_HIST_EN
    logic [1:0]  hist_idx;
    logic [7:0]  hist_data;
    logic [2:0]  hist_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequence_monitor #(.DATA_W(8), .CNT_W(16), .MAX_MISS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .step       (step),
        .state_o    (state_o),
        .seq_locked (seq_locked),
        .exp_data   (exp_data),
        .match_cnt  (match_cnt),
        .err_cnt    (err_cnt),
        .err_pulse  (err_pulse)
`ifdef SEQ_MON_HIST_EN
        ,
        .hist_idx   (hist_idx),
        .hist_data  (hist_data),
        .hist_cnt   (hist_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs are read there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; step = 8'h01;
`ifdef SEQ_MON_HIST_EN
        hist_idx = 2'd0;
`endif
        #12;
        check("rst_state", state_o, 0);
        check("rst_locked", seq_locked, 0);
        check("rst_exp", exp_data, 0);
        check("rst_match", match_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_pulse", err_pulse, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores beats
        beat(8'h33);
        check("idle_ignore_state", state_o, 0);
        check("idle_ignore_exp", exp_data, 0);

        // progression 5,6,7,8 step 1
        step = 8'h01;
        pulse_start();
        check("start_seed", state_o, 1);
        check("seed_unlocked", seq_locked, 0);
        beat(8'd5);
        check("seeded_track", state_o, 2);
        check("seeded_locked", seq_locked, 1);
        check("seeded_exp", exp_data, 6);
        check("seed_not_counted", match_cnt, 0);
        beat(8'd6); beat(8'd7); beat(8'd8);
        check("t1_match", match_cnt, 3);
        check("t1_err", err_cnt, 0);
        check("t1_exp", exp_data, 9);
        check("t1_locked", seq_locked, 1);

        // wrap-around with step 0x10
        step = 8'h10;
        pulse_start();
        check("restart_clear", match_cnt, 0);
        beat(8'hE0); beat(8'hF0); beat(8'h00); beat(8'h10);
        check("wrap_match", match_cnt, 3);
        check("wrap_exp", exp_data, 8'h20);
        check("wrap_err", err_cnt, 0);

        // single mismatch with resync
        step = 8'h01;
        pulse_start();
        beat(8'd1); beat(8'd2);
        check("rs_pre_pulse", err_pulse, 0);
        beat(8'd9);
        check("rs_pulse", err_pulse, 1);
        check("rs_err", err_cnt, 1);
        check("rs_exp", exp_data, 10);
        tick();
        check("rs_pulse_one_cycle", err_pulse, 0);
        beat(8'd10); beat(8'd11);
        check("rs_match", match_cnt, 3);
        check("rs_track", state_o, 2);

        // three consecutive misses -> LOST
        pulse_start();
        beat(8'd1); beat(8'd5); beat(8'd9);
        check("lost_not_yet", state_o, 2);
        beat(8'd13);
        check("lost_state", state_o, 3);
        check("lost_err", err_cnt, 3);
        check("lost_unlocked", seq_locked, 0);
        check("lost_pulse", err_pulse, 1);
        check("lost_exp", exp_data, 14);
`ifdef SEQ_MON_HIST_EN
        check("hist_cnt3", hist_cnt, 3);
        hist_idx = 2'd0; #1;
        check("hist_newest", hist_data, 13);
        hist_idx = 2'd2; #1;
        check("hist_oldest", hist_data, 5);
        hist_idx = 2'd0;
`endif
        beat(8'd14);
        check("lost_ignore_err", err_cnt, 3);
        check("lost_ignore_match", match_cnt, 0);
        check("lost_ignore_pulse", err_pulse, 0);
        check("lost_hold", state_o, 3);

        // start+stop together in TRACK -> stop wins
        pulse_start();
        beat(8'd1); beat(8'd2); beat(8'd3);
        check("ss_pre_match", match_cnt, 2);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_idle", state_o, 0);
        check("ss_match_hold", match_cnt, 2);
        check("ss_exp_hold", exp_data, 4);
        check("ss_unlocked", seq_locked, 0);
        beat(8'd4);
        check("ss_idle_ignore", match_cnt, 2);

        // async reset mid-TRACK
        pulse_start();
        beat(8'd1); beat(8'd2); beat(8'd7);
        check("ar_pre_track", state_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_state", state_o, 0);
        check("ar_locked", seq_locked, 0);
        check("ar_exp", exp_data, 0);
        check("ar_match", match_cnt, 0);
        check("ar_err", err_cnt, 0);
        check("ar_pulse", err_pulse, 0);
`ifdef SEQ_MON_HIST_EN
        check("ar_hist_cnt", hist_cnt, 0);
`endif
        #10;
        rst_n = 1'b1;
        tick();
        check("ar_released_idle", state_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
